// File: rtl/text_lcd_write_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// text_lcd_write_ctrl_pkg
// Shared definitions for the character-LCD write controller:
//   - HD44780-style command constants
//   - default bus timing values, in clock cycles
//   - FSM state encoding
//   - helpers for the init-sequence ROM and for clear/home detection
// -----------------------------------------------------------------------------
package text_lcd_write_ctrl_pkg;

    // Default timing in clock cycles
    localparam int PWRUP_CYC_DEF    = 70;
    localparam int SETUP_CYC_DEF    = 1;
    localparam int E_HIGH_CYC_DEF   = 2;
    localparam int CMD_WAIT_CYC_DEF = 30;
    localparam int CLR_WAIT_CYC_DEF = 100;

    // LCD command bytes
    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] ENTRY_INC     = 8'h06;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] HOME          = 8'h02;
    localparam logic [7:0] HOME_ALT      = 8'h03;
    localparam logic [7:0] DDRAM_L1      = 8'h80;
    localparam logic [7:0] DDRAM_L2      = 8'hC0;

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_SETUP     = 3'd2,
        ST_E_HIGH    = 3'd3,
        ST_WAIT      = 3'd4,
        ST_IDLE      = 3'd5
    } lcd_state_e;

    // Four-entry power-up command ROM
    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = FUNC_SET_8B2L;
            2'd1:    cmd = DISP_ON;
            2'd2:    cmd = ENTRY_INC;
            2'd3:    cmd = CLEAR;
            default: cmd = CLEAR;
        endcase
        return cmd;
    endfunction

    // Clear and home commands need the long post-write wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && ((data == CLEAR) || (data == HOME) || (data == HOME_ALT));
    endfunction

endpackage

// File: rtl/text_lcd_write_ctrl_if.sv
// -----------------------------------------------------------------------------
// text_lcd_write_ctrl_if
// Write-request handshake between two display-content requesters and the LCD
// write controller. A byte transfers in a cycle where reqX_valid and
// reqX_ready are both high.
//   master modport : requester side (drives valid/rs/data, sees ready)
//   slave modport  : controller side (sees valid/rs/data, drives ready)
// -----------------------------------------------------------------------------
interface text_lcd_write_ctrl_if;
    logic       req0_valid;
    logic       req0_rs;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic       req1_rs;
    logic [7:0] req1_data;
    logic       req1_ready;

    modport master (
        output req0_valid, req0_rs, req0_data,
        output req1_valid, req1_rs, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_rs, req0_data,
        input  req1_valid, req1_rs, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/text_lcd_write_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// lcd_rr_arb2
// Two-input round-robin arbiter. The pointer names the input with priority;
// it starts at input 0 and flips to the other input only after a grant.
//   clk, rst  : clock, asynchronous active-low reset
//   valid[1:0]: request lines
//   enable    : arbitration allowed this cycle
//   grant[1:0]: one-hot grant (all zero when disabled or no request)
// -----------------------------------------------------------------------------
module lcd_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);
    logic ptr_r;   // 0: input 0 has priority, 1: input 1 has priority

    // Grant selection from the priority pointer
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (ptr_r == 1'b0) begin
                if (valid[0])      grant = 2'b01;
                else if (valid[1]) grant = 2'b10;
                else               grant = 2'b00;
            end else begin
                if (valid[1])      grant = 2'b10;
                else if (valid[0]) grant = 2'b01;
                else               grant = 2'b00;
            end
        end else begin
            grant = 2'b00;
        end
    end

    // Pointer moves away from whichever input was just granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= 1'b0;
        end else if (grant[0]) begin
            ptr_r <= 1'b1;
        end else if (grant[1]) begin
            ptr_r <= 1'b0;
        end else begin
            ptr_r <= ptr_r;
        end
    end
endmodule

// File: rtl/text_lcd_write_ctrl.sv
// -----------------------------------------------------------------------------
// text_lcd_write_ctrl
// Owns the character-LCD bus. After reset it idles PWRUP_CYC cycles, writes
// the four-command init sequence, raises init_done, then serves byte writes
// from two requesters in round-robin order. Every write is framed as
// SETUP (RS/DATA stable, E=0) -> E_HIGH -> WAIT (E=0, long wait after
// clear/home).
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   req        : two-requester write handshake (slave side)
//   init_done  : init sequence complete, held until reset
//   busy       : FSM not in IDLE
//   LCD_E/LCD_RS/LCD_RW/LCD_DATA : LCD pins (RW tied low, write only)
// -----------------------------------------------------------------------------
module text_lcd_write_ctrl
    import text_lcd_write_ctrl_pkg::*;
#(
    parameter int PWRUP_CYC    = PWRUP_CYC_DEF,
    parameter int SETUP_CYC    = SETUP_CYC_DEF,
    parameter int E_HIGH_CYC   = E_HIGH_CYC_DEF,
    parameter int CMD_WAIT_CYC = CMD_WAIT_CYC_DEF,
    parameter int CLR_WAIT_CYC = CLR_WAIT_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    text_lcd_write_ctrl_if.slave  req,
    output logic                  init_done,
    output logic                  busy,
    output logic                  LCD_E,
    output logic                  LCD_RS,
    output logic                  LCD_RW,
    output logic [7:0]            LCD_DATA
);
    // All phases share one 8-bit down-counter
    if ((PWRUP_CYC > 255) || (SETUP_CYC > 255) || (E_HIGH_CYC > 255) ||
        (CMD_WAIT_CYC > 255) || (CLR_WAIT_CYC > 255)) begin : g_cfg_range
        $error("text_lcd_write_ctrl: timing parameter exceeds 8-bit counter range");
    end
    // The last power-up / inter-command wait cycle is spent in INIT_LOAD
    if ((PWRUP_CYC < 2) || (SETUP_CYC < 1) || (E_HIGH_CYC < 1) ||
        (CMD_WAIT_CYC < 2) || (CLR_WAIT_CYC < 2)) begin : g_cfg_min
        $error("text_lcd_write_ctrl: timing parameter below minimum");
    end

    // Counter load values: a phase of D cycles loads D-1; during init the
    // INIT_LOAD cycle counts as the final cycle of the preceding idle time.
    localparam logic [7:0] PWRUP_LD    = 8'(PWRUP_CYC - 2);
    localparam logic [7:0] SETUP_LD    = 8'(SETUP_CYC - 1);
    localparam logic [7:0] E_HIGH_LD   = 8'(E_HIGH_CYC - 1);
    localparam logic [7:0] CMD_LD      = 8'(CMD_WAIT_CYC - 1);
    localparam logic [7:0] CMD_LD_INIT = 8'(CMD_WAIT_CYC - 2);
    localparam logic [7:0] CLR_LD      = 8'(CLR_WAIT_CYC - 1);
    localparam logic [7:0] CLR_LD_INIT = 8'(CLR_WAIT_CYC - 2);

    lcd_state_e state_r, state_nxt;
    logic [7:0] cnt_r, cnt_nxt;
    logic [1:0] init_idx_r, init_idx_nxt;
    logic       init_done_r, init_done_nxt;
    logic       rs_r, rs_nxt;
    logic [7:0] data_r, data_nxt;
    logic       lcd_e_r;
    logic       busy_r;

    logic       arb_en_s;
    logic [1:0] grant_s;
    logic       cnt_zero_s;
    logic       more_init_s;
    logic [7:0] wait_ld_s;

    assign arb_en_s    = (state_r == ST_IDLE) && init_done_r;
    assign cnt_zero_s  = (cnt_r == 8'd0);
    assign more_init_s = !init_done_r && (init_idx_r != 2'd3);

    lcd_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req.req1_valid, req.req0_valid}),
        .enable (arb_en_s),
        .grant  (grant_s)
    );

    // Ready is the grant itself so a requester dropping valid never transfers
    assign req.req0_ready = grant_s[0];
    assign req.req1_ready = grant_s[1];

    // Wait length for the byte currently on the bus
    always_comb begin
        wait_ld_s = CMD_LD;
        if (is_long_cmd(rs_r, data_r)) begin
            wait_ld_s = more_init_s ? CLR_LD_INIT : CLR_LD;
        end else begin
            wait_ld_s = more_init_s ? CMD_LD_INIT : CMD_LD;
        end
    end

    // Next-state, counter and bus-latch logic
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        init_idx_nxt  = init_idx_r;
        init_done_nxt = init_done_r;
        rs_nxt        = rs_r;
        data_nxt      = data_r;
        case (state_r)
            ST_PWRUP: begin
                if (cnt_zero_s) begin
                    state_nxt = ST_INIT_LOAD;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt   = cnt_r - 8'd1;
                end
            end
            ST_INIT_LOAD: begin
                state_nxt = ST_SETUP;
                cnt_nxt   = SETUP_LD;
                rs_nxt    = 1'b0;
                data_nxt  = init_rom(init_idx_r);
            end
            ST_SETUP: begin
                if (cnt_zero_s) begin
                    state_nxt = ST_E_HIGH;
                    cnt_nxt   = E_HIGH_LD;
                end else begin
                    cnt_nxt   = cnt_r - 8'd1;
                end
            end
            ST_E_HIGH: begin
                if (cnt_zero_s) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = wait_ld_s;
                end else begin
                    cnt_nxt   = cnt_r - 8'd1;
                end
            end
            ST_WAIT: begin
                if (!cnt_zero_s) begin
                    cnt_nxt = cnt_r - 8'd1;
                end else if (more_init_s) begin
                    state_nxt    = ST_INIT_LOAD;
                    init_idx_nxt = init_idx_r + 2'd1;
                end else begin
                    state_nxt     = ST_IDLE;
                    init_done_nxt = 1'b1;
                end
            end
            ST_IDLE: begin
                if (grant_s[0]) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = SETUP_LD;
                    rs_nxt    = req.req0_rs;
                    data_nxt  = req.req0_data;
                end else if (grant_s[1]) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = SETUP_LD;
                    rs_nxt    = req.req1_rs;
                    data_nxt  = req.req1_data;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt     = ST_PWRUP;
                cnt_nxt       = PWRUP_LD;
                init_idx_nxt  = 2'd0;
                init_done_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and registered pin drivers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_PWRUP;
            cnt_r       <= PWRUP_LD;
            init_idx_r  <= 2'd0;
            init_done_r <= 1'b0;
            rs_r        <= 1'b0;
            data_r      <= 8'h00;
            lcd_e_r     <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            init_idx_r  <= init_idx_nxt;
            init_done_r <= init_done_nxt;
            rs_r        <= rs_nxt;
            data_r      <= data_nxt;
            lcd_e_r     <= (state_nxt == ST_E_HIGH);
            busy_r      <= (state_nxt != ST_IDLE);
        end
    end

    assign init_done = init_done_r;
    assign busy      = busy_r;
    assign LCD_E     = lcd_e_r;
    assign LCD_RS    = rs_r;
    assign LCD_RW    = 1'b0;
    assign LCD_DATA  = data_r;
endmodule
